// File: rtl/pipelined_shifter_if.sv
// Request/response bundle for the pipelined shifter: valid/ready request side
// carrying operand, shift amount, select and tag; valid/ready result side.
interface pipelined_shifter_if #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
);
  localparam int SHAMT_W = $clog2(WIDTH);

  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in1;
  logic [SHAMT_W-1:0] shamt;
  logic [2:0]         shifter_select;
  logic [TAG_W-1:0]   in_tag;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   shifter_result;
  logic [TAG_W-1:0]   out_tag;

  modport master (
    output in_valid, in1, shamt, shifter_select, in_tag, out_ready,
    input  in_ready, out_valid, shifter_result, out_tag
  );

  modport slave (
    input  in_valid, in1, shamt, shifter_select, in_tag, out_ready,
    output in_ready, out_valid, shifter_result, out_tag
  );
endinterface

// File: rtl/pipelined_shifter.sv
// Logarithmic shifter (sll/srl/sra/rotl/rotr) split over STAGES register stages
// that advance in lockstep; a tag rides along with every operation.
module pipelined_shifter #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2,
  parameter int TAG_W  = 5
) (
  input logic               clk,
  input logic               rst,
  pipelined_shifter_if.slave bus
);
  localparam int SHAMT_W = $clog2(WIDTH);
  localparam int LPS     = (SHAMT_W + STAGES - 1) / STAGES;

  // One layer: shift by a fixed power of two with the fill the select asks for.
  function automatic logic [WIDTH-1:0] shift_by(input logic [WIDTH-1:0] d,
                                                input logic [2:0] sel,
                                                input logic sign,
                                                input int n);
    logic [WIDTH-1:0] fill;
    fill = sign ? ~({WIDTH{1'b1}} >> n) : '0;
    case (sel)
      3'd1:    return d << n;
      3'd2:    return d >> n;
      3'd3:    return (d >> n) | fill;
      3'd4:    return (d << n) | (d >> (WIDTH - n));
      3'd5:    return (d >> n) | (d << (WIDTH - n));
      default: return '0;
    endcase
  endfunction

  // Apply layers lo..hi-1, lowest first; unused select codes collapse to zero.
  function automatic logic [WIDTH-1:0] shift_layers(input logic [WIDTH-1:0] d,
                                                    input logic [SHAMT_W-1:0] sh,
                                                    input logic [2:0] sel,
                                                    input logic sign,
                                                    input int lo,
                                                    input int hi);
    logic [WIDTH-1:0] r;
    r = d;
    if (sel == 3'd0 || sel > 3'd5) begin
      r = '0;
    end else begin
      for (int i = 0; i < SHAMT_W; i++) begin
        if (i >= lo && i < hi && sh[i]) r = shift_by(r, sel, sign, 1 << i);
      end
    end
    return r;
  endfunction

  function automatic int hi_of(input int s);
    return ((s + 1) * LPS > SHAMT_W) ? SHAMT_W : (s + 1) * LPS;
  endfunction

  logic               vld_p   [STAGES];
  logic [WIDTH-1:0]   data_p  [STAGES];
  logic [SHAMT_W-1:0] shamt_p [STAGES];
  logic [2:0]         sel_p   [STAGES];
  logic               sign_p  [STAGES];
  logic [TAG_W-1:0]   tag_p   [STAGES];
  logic               adv;

  assign adv          = !vld_p[STAGES-1] || bus.out_ready;
  assign bus.in_ready = adv;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < STAGES; s++) begin
        vld_p[s]   <= 1'b0;
        data_p[s]  <= '0;
        shamt_p[s] <= '0;
        sel_p[s]   <= '0;
        sign_p[s]  <= 1'b0;
        tag_p[s]   <= '0;
      end
    end else if (adv) begin
      // stage 0: first group of layers straight from the request
      vld_p[0]   <= bus.in_valid;
      data_p[0]  <= shift_layers(bus.in1, bus.shamt, bus.shifter_select,
                                 bus.in1[WIDTH-1], 0, hi_of(0));
      shamt_p[0] <= bus.shamt;
      sel_p[0]   <= bus.shifter_select;
      sign_p[0]  <= bus.in1[WIDTH-1];
      tag_p[0]   <= bus.in_tag;
      // stages 1..STAGES-1: remaining layer groups on the carried partial result
      for (int s = 1; s < STAGES; s++) begin
        vld_p[s]   <= vld_p[s-1];
        data_p[s]  <= shift_layers(data_p[s-1], shamt_p[s-1], sel_p[s-1],
                                   sign_p[s-1], s * LPS, hi_of(s));
        shamt_p[s] <= shamt_p[s-1];
        sel_p[s]   <= sel_p[s-1];
        sign_p[s]  <= sign_p[s-1];
        tag_p[s]   <= tag_p[s-1];
      end
    end
  end

  assign bus.out_valid      = vld_p[STAGES-1];
  assign bus.shifter_result = data_p[STAGES-1];
  assign bus.out_tag        = tag_p[STAGES-1];
endmodule

// File: tb/tb_pipelined_shifter.sv
// Bench for pipelined_shifter: directed scenarios on a STAGES=2 instance and a
// randomized sweep over STAGES=1/5 (WIDTH=32) and STAGES=3 (WIDTH=64).
module tb_pipelined_shifter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;

  typedef struct {
    logic [63:0] r;
    logic [4:0]  t;
    int          due;
  } exp_t;

  pipelined_shifter_if #(.WIDTH(32), .TAG_W(5)) m ();
  pipelined_shifter #(.WIDTH(32), .STAGES(2), .TAG_W(5)) dut (.clk(clk), .rst(rst), .bus(m));

  pipelined_shifter_if #(.WIDTH(32), .TAG_W(5)) b1 ();
  pipelined_shifter_if #(.WIDTH(32), .TAG_W(5)) b5 ();
  pipelined_shifter_if #(.WIDTH(64), .TAG_W(5)) b3 ();
  pipelined_shifter #(.WIDTH(32), .STAGES(1), .TAG_W(5)) u_s1 (.clk(clk), .rst(rst), .bus(b1));
  pipelined_shifter #(.WIDTH(32), .STAGES(5), .TAG_W(5)) u_s5 (.clk(clk), .rst(rst), .bus(b5));
  pipelined_shifter #(.WIDTH(64), .STAGES(3), .TAG_W(5)) u_s3 (.clk(clk), .rst(rst), .bus(b3));

  logic        sw_valid = 1'b0;
  logic [63:0] sw_in1   = '0;
  logic [5:0]  sw_shamt = '0;
  logic [2:0]  sw_sel   = '0;
  logic [4:0]  sw_tag   = '0;

  assign b1.in_valid = sw_valid;  assign b1.in1 = sw_in1[31:0];  assign b1.shamt = sw_shamt[4:0];
  assign b1.shifter_select = sw_sel;  assign b1.in_tag = sw_tag;  assign b1.out_ready = 1'b1;
  assign b5.in_valid = sw_valid;  assign b5.in1 = sw_in1[31:0];  assign b5.shamt = sw_shamt[4:0];
  assign b5.shifter_select = sw_sel;  assign b5.in_tag = sw_tag;  assign b5.out_ready = 1'b1;
  assign b3.in_valid = sw_valid;  assign b3.in1 = sw_in1;        assign b3.shamt = sw_shamt;
  assign b3.shifter_select = sw_sel;  assign b3.in_tag = sw_tag;  assign b3.out_ready = 1'b1;

  logic        ov   [3];
  logic        ir   [3];
  logic [63:0] sres [3];
  logic [4:0]  stag [3];
  assign ov[0] = b1.out_valid;  assign ir[0] = b1.in_ready;
  assign ov[1] = b5.out_valid;  assign ir[1] = b5.in_ready;
  assign ov[2] = b3.out_valid;  assign ir[2] = b3.in_ready;
  assign sres[0] = {32'h0, b1.shifter_result};  assign stag[0] = b1.out_tag;
  assign sres[1] = {32'h0, b5.shifter_result};  assign stag[1] = b5.out_tag;
  assign sres[2] = b3.shifter_result;           assign stag[2] = b3.out_tag;

  int sw_w  [3] = '{32, 32, 64};
  int sw_st [3] = '{1, 5, 3};

  // Whole-word reference: one shift of the full distance on a w-bit value.
  function automatic logic [63:0] model(input int w, input logic [63:0] x,
                                        input int sh, input logic [2:0] sel);
    logic [63:0] mask, v, srl;
    mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    v    = x & mask;
    srl  = v >> sh;
    case (sel)
      3'd1:    return (v << sh) & mask;
      3'd2:    return srl;
      3'd3:    return v[w-1] ? (srl | (mask & ~(mask >> sh))) : srl;
      3'd4:    return ((v << sh) | (v >> (w - sh))) & mask;
      3'd5:    return ((v >> sh) | (v << (w - sh))) & mask;
      default: return 64'd0;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drive(input logic v, input logic [31:0] x, input logic [4:0] sh,
                       input logic [2:0] sel, input logic [4:0] t);
    m.in_valid = v;
    m.in1 = x;
    m.shamt = sh;
    m.shifter_select = sel;
    m.in_tag = t;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    m.out_ready = 1'b1;
    drive(1'b1, 32'hDEAD_BEEF, 5'd3, 3'd1, 5'd7);
    for (int i = 0; i < 2; i++) begin
      tick();
      vectors++;
      if (m.out_valid !== 1'b0 || m.shifter_result !== 32'h0 || m.out_tag !== 5'h0) begin
        errors++;
        $display("FAIL reset[%0d]: valid=%b result=%h tag=%h, required 0/0/0",
                 i, m.out_valid, m.shifter_result, m.out_tag);
      end
    end
    rst = 1'b0;
    drive(1'b1, 32'h0000_00F1, 5'd4, 3'd1, 5'd9);
    #1;
    vectors++;
    if (m.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: in_ready=%b, required 1", m.in_ready);
    end
    tick();
    drive(1'b0, 32'h0, 5'd0, 3'd0, 5'd0);
    vectors++;
    if (m.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL first_early: valid=%b, required 0", m.out_valid);
    end
    tick();
    vectors++;
    if (m.out_valid !== 1'b1 || m.shifter_result !== 32'h0000_0F10 || m.out_tag !== 5'd9) begin
      errors++;
      $display("FAIL first_result: valid=%b result=%h tag=%0d, required 1 00000f10 9",
               m.out_valid, m.shifter_result, m.out_tag);
    end
    tick();
    vectors++;
    if (m.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL first_drain: valid=%b, required 0", m.out_valid);
    end
  endtask

  task automatic test_basic();
    logic [31:0] expv [5];
    expv = '{32'h0000_0F10, 32'h0800_000F, 32'hF800_000F, 32'h0000_0F18, 32'h1800_000F};
    for (int j = 0; j < 7; j++) begin
      if (j < 5) drive(1'b1, 32'h8000_00F1, 5'd4, 3'(j + 1), 5'(j + 1));
      else       drive(1'b0, 32'h0, 5'd0, 3'd0, 5'd0);
      tick();
      vectors++;
      if (j == 0 || j == 6) begin
        if (m.out_valid !== 1'b0) begin
          errors++;
          $display("FAIL basic_idle[%0d]: valid=%b, required 0", j, m.out_valid);
        end
      end else if (m.out_valid !== 1'b1 || m.shifter_result !== expv[j-1] ||
                   m.out_tag !== 5'(j)) begin
        errors++;
        $display("FAIL basic[%0d]: valid=%b result=%h tag=%0d, required 1 %h %0d",
                 j - 1, m.out_valid, m.shifter_result, m.out_tag, expv[j-1], j);
      end
    end
  endtask

  task automatic test_boundaries();
    logic [31:0] bx  [4];
    logic [4:0]  bsh [4];
    logic [2:0]  bsl [4];
    logic [4:0]  btg [4];
    logic [31:0] bex [4];
    int n;
    bx  = '{$urandom, 32'h8000_0000, 32'h0000_0001, $urandom};
    bsh = '{5'd0, 5'd31, 5'd31, 5'd7};
    bsl = '{3'd3, 3'd3, 3'd4, 3'd6};
    btg = '{5'd11, 5'd12, 5'd13, 5'd26};
    bex = '{bx[0], 32'hFFFF_FFFF, 32'h8000_0000, 32'h0};
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, bx[k], bsh[k], bsl[k], btg[k]);
      tick();
      drive(1'b0, 32'h0, 5'd0, 3'd0, 5'd0);
      n = 0;
      while (m.out_valid !== 1'b1 && n < 10) begin
        tick();
        n++;
      end
      vectors++;
      if (m.out_valid !== 1'b1 || m.shifter_result !== bex[k] || m.out_tag !== btg[k] || n != 1) begin
        errors++;
        $display("FAIL boundary[%0d]: valid=%b result=%h tag=%0d extra_cycles=%0d, required 1 %h %0d 1",
                 k, m.out_valid, m.shifter_result, m.out_tag, n, bex[k], btg[k]);
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    exp_t q[$];
    exp_t e;
    int sent = 0, got = 0, stall = 0;
    bit seen = 0;
    logic ordy;
    logic [31:0] x;
    logic [4:0]  sh;
    logic [2:0]  sel;
    for (int c = 0; c < 40 && got < 4; c++) begin
      if (m.out_valid === 1'b1) begin
        vectors++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL bp_extra: result=%h tag=%0d, required no result", m.shifter_result, m.out_tag);
        end else if (m.shifter_result !== q[0].r[31:0] || m.out_tag !== q[0].t) begin
          errors++;
          $display("FAIL bp_result: result=%h tag=%0d, required %h %0d",
                   m.shifter_result, m.out_tag, q[0].r[31:0], q[0].t);
        end
        seen = 1;
      end
      ordy = 1'b1;
      if (seen && stall < 3) begin
        ordy = 1'b0;
        stall++;
      end
      m.out_ready = ordy;
      if (sent < 4) begin
        x = $urandom;  sh = 5'($urandom);  sel = 3'($urandom_range(1, 5));
        drive(1'b1, x, sh, sel, 5'(20 + sent));
      end else begin
        drive(1'b0, 32'h0, 5'd0, 3'd0, 5'd0);
      end
      #1;
      if (!ordy && m.out_valid === 1'b1) begin
        vectors++;
        if (m.in_ready !== 1'b0) begin
          errors++;
          $display("FAIL bp_ready: in_ready=%b while stalled, required 0", m.in_ready);
        end
      end
      if (m.in_valid && m.in_ready === 1'b1) begin
        e.r = model(32, {32'h0, x}, int'(sh), sel);
        e.t = 5'(20 + sent);
        e.due = 0;
        q.push_back(e);
        sent++;
      end
      if (m.out_valid === 1'b1 && ordy && q.size() > 0) begin
        void'(q.pop_front());
        got++;
      end
      tick();
    end
    m.out_ready = 1'b1;
    vectors++;
    if (got != 4 || q.size() != 0 || m.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_count: delivered=%0d pending=%0d valid=%b, required 4 0 0",
               got, q.size(), m.out_valid);
    end
  endtask

  task automatic test_reset_midflight();
    logic [31:0] x;
    logic [4:0]  sh;
    drive(1'b1, $urandom, 5'($urandom), 3'd4, 5'd3);
    tick();
    rst = 1'b1;
    drive(1'b1, $urandom, 5'($urandom), 3'd2, 5'd4);
    tick();
    rst = 1'b0;
    drive(1'b0, 32'h0, 5'd0, 3'd0, 5'd0);
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (m.out_valid !== 1'b0) begin
        errors++;
        $display("FAIL midrst_quiet[%0d]: valid=%b tag=%0d, required 0", i, m.out_valid, m.out_tag);
      end
      tick();
    end
    x = $urandom;
    sh = 5'($urandom_range(1, 31));
    drive(1'b1, x, sh, 3'd3, 5'd17);
    tick();
    drive(1'b0, 32'h0, 5'd0, 3'd0, 5'd0);
    tick();
    vectors++;
    if (m.out_valid !== 1'b1 || m.shifter_result !== model(32, {32'h0, x}, int'(sh), 3'd3) ||
        m.out_tag !== 5'd17) begin
      errors++;
      $display("FAIL midrst_after: valid=%b result=%h tag=%0d, required 1 %h 17",
               m.out_valid, m.shifter_result, m.out_tag, model(32, {32'h0, x}, int'(sh), 3'd3));
    end
    tick();
  endtask

  task automatic test_sweep();
    exp_t sq[3][$];
    exp_t e;
    bit expv;
    int sh;
    for (int c = 0; c < 310; c++) begin
      for (int k = 0; k < 3; k++) begin
        expv = (sq[k].size() > 0) && (sq[k][0].due == cyc);
        vectors++;
        if (ov[k] !== expv || ir[k] !== 1'b1) begin
          errors++;
          $display("FAIL sweep_valid[%0d] cyc %0d: valid=%b in_ready=%b, required %b 1",
                   k, cyc, ov[k], ir[k], expv);
        end else if (expv && (sres[k] !== sq[k][0].r || stag[k] !== sq[k][0].t)) begin
          errors++;
          $display("FAIL sweep_result[%0d] cyc %0d: result=%h tag=%0d, required %h %0d",
                   k, cyc, sres[k], stag[k], sq[k][0].r, sq[k][0].t);
        end
        if (expv) void'(sq[k].pop_front());
      end
      if (c < 300) begin
        sw_valid = ($urandom_range(0, 3) != 0);
        sw_in1   = {$urandom, $urandom};
        if (c % 16 == 0) sw_in1 = 64'h8000_0000_8000_0000;
        sw_shamt = 6'($urandom);
        if (c % 23 == 0) sw_shamt = 6'h3F;
        sw_sel   = 3'($urandom_range(0, 7));
        sw_tag   = 5'($urandom);
      end else begin
        sw_valid = 1'b0;
      end
      if (sw_valid) begin
        for (int k = 0; k < 3; k++) begin
          sh = (sw_w[k] == 64) ? int'(sw_shamt) : int'(sw_shamt[4:0]);
          e.r = model(sw_w[k], sw_in1, sh, sw_sel);
          e.t = sw_tag;
          e.due = cyc + sw_st[k];
          sq[k].push_back(e);
        end
      end
      tick();
    end
    for (int k = 0; k < 3; k++) begin
      vectors++;
      if (sq[k].size() != 0) begin
        errors++;
        $display("FAIL sweep_drain[%0d]: pending=%0d, required 0", k, sq[k].size());
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_boundaries();
    test_backpressure();
    test_reset_midflight();
    test_sweep();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
